// File: rtl/ton_msg_sequencer.sv
// ton_msg_sequencer: latches one PoW job and streams 123-byte candidate messages.
// Optional TON_NONCE_OUT_EN adds o_nonce, the per-job message index.
module ton_msg_sequencer #(
  parameter int N_CH = 4,
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] STRIDE = CNT_W'(1),
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_job_valid,
  output logic             o_job_ready,
  input  logic [7:0]       i_d1,
  input  logic [7:0]       i_d2,
  input  logic [31:0]      i_op,
  input  logic [7:0]       i_flags,
  input  logic [31:0]      i_expire,
  input  logic [255:0]     i_myaddr,
  input  logic [255:0]     i_rdata,
  input  logic [127:0]     i_pseed,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_abort,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [983:0]     o_data,
  output logic [CH_W-1:0]  o_chan,
  output logic             o_last,
  output logic             o_busy,
`ifdef TON_NONCE_OUT_EN
  output logic [CNT_W-1:0] o_nonce,
`endif
  output logic             o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [255:0] STEP = 256'(STRIDE);
  localparam logic [CH_W-1:0] CH_MAX = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state;
  logic [7:0]       d1;
  logic [7:0]       d2;
  logic [31:0]      op;
  logic [7:0]       flags;
  logic [31:0]      expire;
  logic [255:0]     myaddr;
  logic [127:0]     pseed;
  logic [255:0]     cur_rdata;
  logic [CNT_W-1:0] remaining;
  logic             hs;
  logic             accept;
  logic             final_beat;

  assign hs = o_valid & i_ready;
  assign accept = o_job_ready & i_job_valid;
  assign final_beat = hs && (remaining == ONE);

  // Message image: cur_rdata appears twice, at bytes 43..74 and 91..122.
  assign o_data = {d1, d2, op, flags, expire, myaddr,
                   cur_rdata, pseed, cur_rdata};

  // Job field latch, taken only on job accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d1     <= '0;
      d2     <= '0;
      op     <= '0;
      flags  <= '0;
      expire <= '0;
      myaddr <= '0;
      pseed  <= '0;
    end else if (state == IDLE && accept) begin
      d1     <= i_d1;
      d2     <= i_d2;
      op     <= i_op;
      flags  <= i_flags;
      expire <= i_expire;
      myaddr <= i_myaddr;
      pseed  <= i_pseed;
    end
  end

  // Running rdata, remaining count and channel; advance once per handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_rdata <= '0;
      remaining <= '0;
      o_chan    <= '0;
    end else if (state == IDLE && accept) begin
      cur_rdata <= i_rdata;
      remaining <= i_count;
      o_chan    <= '0;
    end else if (state == RUN && hs) begin
      cur_rdata <= cur_rdata + STEP;
      remaining <= remaining - ONE;
      o_chan    <= (o_chan == CH_MAX) ? '0 : o_chan + CH_W'(1);
    end
  end

`ifdef TON_NONCE_OUT_EN
  // Zero-based message index within the job.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_nonce <= '0;
    end else if (state == IDLE && accept) begin
      o_nonce <= '0;
    end else if (state == RUN && hs) begin
      o_nonce <= o_nonce + ONE;
    end
  end
`endif

  // Control FSM; every handshake/status output is registered from next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_job_ready <= 1'b0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          o_job_ready <= 1'b1;
          if (accept) begin
            o_job_ready <= 1'b0;
            o_busy      <= 1'b1;
            if (i_count != '0) begin
              state   <= RUN;
              o_valid <= 1'b1;
              o_last  <= (i_count == ONE);
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_abort || final_beat) begin
            state   <= DONE;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_done  <= 1'b1;
          end else if (hs) begin
            o_last <= (remaining == TWO);
          end
        end
        DONE: begin
          state       <= IDLE;
          o_busy      <= 1'b0;
          o_job_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_valid     <= 1'b0;
          o_last      <= 1'b0;
          o_busy      <= 1'b0;
          o_job_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
